// File: rtl/ropuf_pair_ctrl.sv
// RO-PUF pair sequencer. For each response bit it enables the challenge-selected RO pair,
// lets the pair settle, counts synchronized rising edges of both ROs over a programmable
// window and shifts (cnt_a > cnt_b) into the response.
// Optional build macro ROPUF_PAIR_CTRL_TIE_FLAG_EN adds a per-bit tie flag output.
// SETTLE_CYC is assumed to be at least 1.
module ropuf_pair_ctrl #(
  parameter int unsigned NUM_RO     = 4,
  parameter int unsigned NBITS      = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [NBITS*2*$clog2(NUM_RO)-1:0]   challenge,
  input  logic [WIN_W-1:0]                    window,
  output logic [NUM_RO-1:0]                   ro_en,
  input  logic [NUM_RO-1:0]                   ro_out,
  output logic                                busy,
  output logic                                done,
  output logic [NBITS-1:0]                    response
`ifdef ROPUF_PAIR_CTRL_TIE_FLAG_EN
  ,
  output logic [NBITS-1:0]                    tie
`endif
);

  localparam int unsigned SEL_W = $clog2(NUM_RO);
  localparam int unsigned CH_W  = NBITS * 2 * SEL_W;
  localparam int unsigned IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [TMR_W-1:0] SettleLd  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(NBITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StMeasure,
    StCompare,
    StDone
  } state_e;

  state_e            state_q;
  logic [CH_W-1:0]   chal_q;
  logic [WIN_W-1:0]  win_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [CNT_W-1:0]  cnt_a_q;
  logic [CNT_W-1:0]  cnt_b_q;

  logic [NUM_RO-1:0] sync1_q;
  logic [NUM_RO-1:0] sync2_q;
  logic [NUM_RO-1:0] prev_q;

  logic [NUM_RO-1:0] edge_v;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              inc_a;
  logic              inc_b;
  logic [WIN_W-1:0]  win_eff;

  // One-hot (or single-bit when a == b) enable mask for bit i of a challenge word.
  // Indices >= NUM_RO contribute no enable bit.
  function automatic logic [NUM_RO-1:0] pair_mask(input logic [CH_W-1:0] ch,
                                                  input int unsigned i);
    logic [SEL_W-1:0]  a;
    logic [SEL_W-1:0]  b;
    logic [NUM_RO-1:0] m;
    a = ch[i*2*SEL_W +: SEL_W];
    b = ch[i*2*SEL_W+SEL_W +: SEL_W];
    m = '0;
    for (int unsigned r = 0; r < NUM_RO; r++) begin
      if (SEL_W'(r) == a || SEL_W'(r) == b) m[r] = 1'b1;
    end
    return m;
  endfunction

  // Two-flop synchronizer plus previous-value flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ro_out;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Route the selected pair's edge pulses to the two counters; out-of-range picks never count.
  always_comb begin
    edge_v  = sync2_q & ~prev_q;
    sel_a   = chal_q[int'(idx_q)*2*SEL_W +: SEL_W];
    sel_b   = chal_q[int'(idx_q)*2*SEL_W+SEL_W +: SEL_W];
    inc_a   = (int'(sel_a) < int'(NUM_RO)) ? edge_v[sel_a] : 1'b0;
    inc_b   = (int'(sel_b) < int'(NUM_RO)) ? edge_v[sel_b] : 1'b0;
    win_eff = (window == '0) ? WIN_W'(1) : window;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      chal_q   <= '0;
      win_q    <= '0;
      idx_q    <= '0;
      tmr_q    <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      ro_en    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= '0;
`ifdef ROPUF_PAIR_CTRL_TIE_FLAG_EN
      tie      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            chal_q   <= challenge;
            win_q    <= win_eff;
            idx_q    <= '0;
            response <= '0;
`ifdef ROPUF_PAIR_CTRL_TIE_FLAG_EN
            tie      <= '0;
`endif
            ro_en    <= pair_mask(challenge, 0);
            busy     <= 1'b1;
            tmr_q    <= SettleLd;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            state_q  <= StSettle;
          end
        end

        StSettle: begin
          if (tmr_q == '0) begin
            tmr_q   <= TMR_W'(win_q) - 1'b1;
            state_q <= StMeasure;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        StMeasure: begin
          if (inc_a && cnt_a_q != CntMax) cnt_a_q <= cnt_a_q + 1'b1;
          if (inc_b && cnt_b_q != CntMax) cnt_b_q <= cnt_b_q + 1'b1;
          if (tmr_q == '0) begin
            // Pair goes dark for the compare cycle.
            ro_en   <= '0;
            state_q <= StCompare;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        StCompare: begin
          response[idx_q] <= (cnt_a_q > cnt_b_q);
`ifdef ROPUF_PAIR_CTRL_TIE_FLAG_EN
          tie[idx_q]      <= (cnt_a_q == cnt_b_q);
`endif
          if (idx_q == LastIdx) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 1'b1;
            ro_en   <= pair_mask(chal_q, int'(idx_q) + 1);
            tmr_q   <= SettleLd;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            state_q <= StSettle;
          end
        end

        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          ro_en   <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ropuf_pair_ctrl.sv
// Bench for ropuf_pair_ctrl: RO waveforms are deterministic functions of the cycle number,
// so a reference model can count the edges each RO shows inside every measurement window.
// Expected results go into a scoreboard; a monitor pops them on done. A per-cycle checker
// compares ro_en/busy/done and the held response against the run schedule.
module tb_ropuf_pair_ctrl;

  localparam int unsigned NUM_RO = 4;
  localparam int unsigned NBITS  = 2;
  localparam int unsigned CNT_W  = 5;   // narrow so saturation is reachable
  localparam int unsigned WIN_W  = 16;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CH_W   = NBITS * 2 * SEL_W;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CH_W-1:0]   challenge = '0;
  logic [WIN_W-1:0]  window = '0;
  logic [NUM_RO-1:0] ro_en;
  logic [NUM_RO-1:0] ro_out = '0;
  logic              busy;
  logic              done;
  logic [NBITS-1:0]  response;
`ifdef ROPUF_PAIR_CTRL_TIE_FLAG_EN
  logic [NBITS-1:0]  tie;
`endif

  ropuf_pair_ctrl #(
    .NUM_RO(NUM_RO), .NBITS(NBITS), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge), .window(window),
    .ro_en(ro_en), .ro_out(ro_out), .busy(busy), .done(done), .response(response)
`ifdef ROPUF_PAIR_CTRL_TIE_FLAG_EN
    , .tie(tie)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RO r is a square wave: half period hp[r] cycles, phase ph[r].
  int hp[NUM_RO];
  int ph[NUM_RO];

  function automatic logic wave(input int r, input int j);
    return (((j + ph[r]) / hp[r]) % 2) == 1;
  endfunction

  initial forever begin
    @(negedge clk);
    for (int r = 0; r < NUM_RO; r++) ro_out[r] = wave(r, cyc);
  end

  // Reference model ------------------------------------------------------------------------
  function automatic int sel_of(input logic [CH_W-1:0] ch, input int i, input int which);
    return int'((ch >> (i * 2 * SEL_W + which * SEL_W)) & ((1 << SEL_W) - 1));
  endfunction

  function automatic logic [NUM_RO-1:0] exp_mask(input logic [CH_W-1:0] ch, input int i);
    logic [NUM_RO-1:0] m;
    int a;
    int b;
    m = '0;
    a = sel_of(ch, i, 0);
    b = sel_of(ch, i, 1);
    if (a < NUM_RO) m[a] = 1'b1;
    if (b < NUM_RO) m[b] = 1'b1;
    return m;
  endfunction

  // Rising edges seen during measurement cycles [first, first+w); the synchronizer delays
  // the RO view by two clocks. Saturates at the counter maximum.
  function automatic int exp_count(input int r, input int first, input int w);
    int c;
    c = 0;
    if (r >= NUM_RO) return 0;
    for (int m = first; m < first + w; m++)
      if (wave(r, m - 2) && !wave(r, m - 3)) c++;
    return (c > CMAX) ? CMAX : c;
  endfunction

  typedef struct {
    logic [NBITS-1:0] resp;
    logic [NBITS-1:0] tie;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  bit               run_on = 1'b0;
  int               run_c0 = 0;
  int               run_w  = 1;
  logic [CH_W-1:0]  run_ch = '0;
  logic [NBITS-1:0] last_resp = '0;

  // Stimulus tasks -------------------------------------------------------------------------
  task automatic issue(input logic [CH_W-1:0] ch, input int win_raw);
    exp_t e;
    int   w;
    int   per;
    int   ca;
    int   cb;
    @(negedge clk);
    w   = (win_raw == 0) ? 1 : win_raw;
    per = SETTLE + w + 1;
    for (int i = 0; i < NBITS; i++) begin
      ca = exp_count(sel_of(ch, i, 0), cyc + 1 + i * per + SETTLE, w);
      cb = exp_count(sel_of(ch, i, 1), cyc + 1 + i * per + SETTLE, w);
      e.resp[i] = (ca > cb);
      e.tie[i]  = (ca == cb);
    end
    e.cyc = cyc + NBITS * per + 1;
    sb.push_back(e);
    run_c0 = cyc;
    run_w  = w;
    run_ch = ch;
    run_on = 1'b1;
    challenge = ch;
    window    = WIN_W'(win_raw);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    challenge = CH_W'($urandom);
    window    = WIN_W'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int run_end();
    return run_c0 + NBITS * (SETTLE + run_w + 1) + 1;
  endfunction

  // Monitor: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("response", response, e.resp);
`ifdef ROPUF_PAIR_CTRL_TIE_FLAG_EN
        chk("tie", tie, e.tie);
`endif
        last_resp = e.resp;
      end
    end
  end

  // Per-cycle schedule checker.
  always @(negedge clk) begin
    int d;
    int per;
    int len;
    logic [NUM_RO-1:0] e_en;
    logic e_busy;
    logic e_done;
    logic idle;
    if (rst_n) begin
      e_en = '0;
      e_busy = 1'b0;
      e_done = 1'b0;
      idle = 1'b1;
      if (run_on) begin
        d   = cyc - run_c0;
        per = SETTLE + run_w + 1;
        len = NBITS * per;
        if (d >= 1 && d <= len) begin
          idle   = 1'b0;
          e_busy = 1'b1;
          if ((d - 1) % per < SETTLE + run_w) e_en = exp_mask(run_ch, (d - 1) / per);
        end else if (d == len + 1) begin
          idle   = 1'b0;
          e_done = 1'b1;
        end
      end
      chk("ro_en", ro_en, e_en);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (idle) chk("held_response", response, last_resp);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Main sequence --------------------------------------------------------------------------
  initial begin
    for (int r = 0; r < NUM_RO; r++) begin
      hp[r] = r + 2;
      ph[r] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ro_en", ro_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_response", response, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run: RO0 period 4, RO1 period 6; pairs (0,1) then (1,0).
    hp[0] = 2; hp[1] = 3;
    issue(8'h14, 100);
    repeat (30) @(negedge clk);
    start = 1'b1;                      // ignored while busy
    @(negedge clk);
    start = 1'b0;
    wait_until(run_end());
    start = 1'b1;                      // ignored in the done cycle
    @(negedge clk);
    start = 1'b0;
    chk("basic_response", response, 2'b01);
    repeat (3) @(negedge clk);

    // Same-RO pair for bit 0, distinct pair for bit 1.
    hp[2] = 2;
    issue(8'b01_11_10_10, 20);
    wait_until(run_end() + 1);
    chk("same_ro_bit0", response[0], 0);

    // Zero window behaves as one.
    issue(8'h1b, 0);
    wait_until(run_end() + 1);

    // Saturation: both selected ROs far exceed the counter range.
    hp[2] = 1; hp[3] = 2;
    issue(8'b10_11_11_10, 200);
    wait_until(run_end() + 1);
    chk("sat_response", response, 0);

    // Asynchronous reset in the middle of measurement.
    hp[0] = 2; hp[1] = 3;
    issue(8'h14, 100);
    wait_until(run_c0 + 1 + SETTLE + 49);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    run_on = 1'b0;
    sb.delete();
    last_resp = '0;
    #1;
    chk("async_rst_ro_en", ro_en, 0);
    chk("async_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(8'h14, 100);
    wait_until(run_end() + 1);
    chk("rerun_response", response, 2'b01);

    // Randomized runs.
    for (int n = 0; n < 25; n++) begin
      for (int r = 0; r < NUM_RO; r++) begin
        hp[r] = $urandom_range(1, 6);
        ph[r] = $urandom_range(0, 11);
      end
      issue(CH_W'($urandom), $urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_until(run_end() + 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ropuf_pair_ctrl.md
Name: ropuf_pair_ctrl

Overview:
- Sequencer for a bank of NUM_RO ring oscillators in the multi-bit RO-PUF.
- Per response bit, enables one challenge-selected RO pair, counts rising edges of each over a programmable window, and compares the counts.
- Shifts the comparison result into a NBITS-wide response, then handshakes completion.
- Sits between the PUF host interface (start/done) and the raw RO instances (ro_en/ro_out).

Parameters:
- NUM_RO, 4, number of ROs in the bank; must be >= 2. Localparam SEL_W = $clog2(NUM_RO).
- NBITS, 2, response bits produced per start.
- CNT_W, 16, edge counter width.
- WIN_W, 16, measurement window length field width.
- SETTLE_CYC, 4, cycles the pair runs before counting starts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- challenge  in  NBITS*2*SEL_W  bit i: a_i = challenge[i*2*SEL_W +: SEL_W], b_i = challenge[i*2*SEL_W+SEL_W +: SEL_W]
- window  in  WIN_W  measurement length in clk cycles; latched at start
- ro_en  out  NUM_RO  per-RO enable, one-hot pair or zero
- ro_out  in  NUM_RO  raw RO outputs, asynchronous to clk
- busy  out  1  high from SETTLE through COMPARE of the last bit
- done  out  1  one-cycle pulse when response is final
- response  out  NBITS  PUF response; bit i = (cnt_a_i > cnt_b_i)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; ro_en, busy, done, response, counters, and bit index all 0. Synchronizers cleared.
- ro_out path: each bit passes through a 2-flop synchronizer, then a rising-edge detector (sync & ~prev). Only the selected pair's detectors feed the counters.
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE:
  - start=1 latches challenge and window, with window=0 treated as 1.
  - Clears bit index and response.
  - Next state SETTLE.
- SETTLE:
  - ro_en = (1<<a_i)|(1<<b_i); busy=1.
  - cnt_a and cnt_b are held at 0.
  - Lasts exactly SETTLE_CYC cycles, then MEASURE.
- MEASURE:
  - ro_en held.
  - Each detected edge increments the respective counter; counters saturate at 2^CNT_W-1.
  - Lasts exactly the latched window cycles, then COMPARE.
- COMPARE (1 cycle):
  - ro_en = 0.
  - response[i] <= (cnt_a > cnt_b). Ties, including a_i == b_i and both saturated, give 0.
  - If i == NBITS-1, next state DONE; otherwise i++ and next state SETTLE.
- DONE (1 cycle): done=1, busy=0, next state IDLE.
- response is stable from DONE until the next accepted start.
- Latency from the start cycle to done = NBITS*(SETTLE_CYC+window+1) + 1 cycles.
- start while not in IDLE is ignored, including in the DONE cycle.
- Out-of-range index (>= NUM_RO, for non-power-of-2 NUM_RO): no ro_en bit for that index; its count stays 0.
- Reset asserted mid-measurement aborts immediately; ro_en drops asynchronously.

Optional Feature:
- Macro: ROPUF_PAIR_CTRL_TIE_FLAG_EN.
- When defined:
  - Adds output tie[NBITS-1:0], reset 0 and cleared on accepted start.
  - tie[i] is set in COMPARE when cnt_a == cnt_b, flagging unreliable bits.
  - Holds with response.
- When undefined: the port and its logic are absent; response behaviour is identical.

Test Plan:
- Basic two-bit run:
  - Stimulus: NUM_RO=4, SETTLE_CYC=4, window=100. Bench drives ro_out[0] with period 4 clk and ro_out[1] with period 6 clk. Challenge: bit0 (a=0,b=1), bit1 (a=1,b=0). start at cycle 0.
  - Required: busy rises at cycle 1; done pulses at cycle 211; response=2'b01.
  - Required ro_en: 4'b0011 in cycles 1-104 and 106-209; 0 in cycles 105 and 210.
- Same-RO pair: a=b=2 -> ro_en=4'b0100 during the pair; response bit = 0; tie bit = 1 when the feature is enabled.
- Window=0 -> behaves as window=1; done at cycle NBITS*(SETTLE_CYC+2)+1 = 13.
- Saturation: CNT_W=4, window=200, both ROs fast -> both counts stick at 15; response bit 0 (tie).
- Reset and ignored start:
  - rst_n low at cycle 50 of MEASURE -> ro_en=0 and busy=0 without waiting for clk.
  - After release, start re-runs cleanly with the same results as the basic run.
  - A start pulse while busy is ignored, with no second done.
